// File: rtl/mmio_fabric_pkg.sv
// Shared definitions for the MMIO fabric: FSM encoding, bus widths,
// the SoC default region map and a small index-to-one-hot helper.
package mmio_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } fab_state_t;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = 4;
    localparam int REGION_W = 4;
    localparam int IDX_W    = 4;
    localparam int TMO_W    = 16;

    // SoC slave indices
    localparam int SLV_RAM    = 0;
    localparam int SLV_RNG    = 1;
    localparam int SLV_VTATTR = 2;
    localparam int SLV_VTDATA = 3;
    localparam int SLV_JOYPAD = 4;
    localparam int SLV_VPAL   = 5;
    localparam int SLV_VCTRL  = 6;
    localparam int SLV_LCD    = 7;
    localparam int SLV_AUDIO  = 8;
    localparam int SOC_N_SLAVES = 9;

    // Region map on addr[31:28], slave 8 leftmost, slave 0 rightmost.
    // RAM 0x0-0x1, RNG 0x2, VTATTR 0x4-0x5 (shadows VTDATA at 0x4),
    // JOYPAD 0x6, VPAL 0x8, VCTRL 0xA, LCD 0xC-0xD, AUDIO 0xE; 0xF unmapped.
    localparam logic [SOC_N_SLAVES*REGION_W-1:0] SOC_REGION_BASE =
        {4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h4, 4'h2, 4'h0};
    localparam logic [SOC_N_SLAVES*REGION_W-1:0] SOC_REGION_MASK =
        {4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hF, 4'hE};

    function automatic logic [15:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/mmio_fabric_if.sv
// CPU-side request/response and peripheral-side select/data signals of the fabric.
interface mmio_fabric_if #(parameter int N_SLAVES = 9);
    logic                   req_valid;
    logic                   req_ready;
    logic [31:0]            req_addr;
    logic [31:0]            req_wdata;
    logic [3:0]             req_wstrb;
    logic                   resp_valid;
    logic [31:0]            resp_rdata;
    logic                   resp_err;
    logic [N_SLAVES-1:0]    slv_sel;
    logic [31:0]            slv_addr;
    logic [31:0]            slv_wdata;
    logic [3:0]             slv_wstrb;
    logic [N_SLAVES-1:0]    slv_ready;
    logic [N_SLAVES*32-1:0] slv_rdata;

    // Fabric side
    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, slv_ready, slv_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               slv_sel, slv_addr, slv_wdata, slv_wstrb
    );

    // CPU plus peripherals side
    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, slv_ready, slv_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               slv_sel, slv_addr, slv_wdata, slv_wstrb
    );
endinterface

// File: rtl/mmio_fabric_region_match.sv
// Address region decoder: per-slave masked compare on addr[31:28] with a
// priority encoder so the lowest-index matching slave wins.
module mmio_region_match
    import mmio_fabric_pkg::*;
#(
    parameter int                         N_SLAVES    = 9,
    parameter logic [N_SLAVES*4-1:0]      REGION_BASE = {N_SLAVES{4'h0}},
    parameter logic [N_SLAVES*4-1:0]      REGION_MASK = {N_SLAVES{4'hE}}
) (
    input  logic [REGION_W-1:0] region,
    output logic                hit,
    output logic [IDX_W-1:0]    idx
);

    // Scan high to low so the last (lowest) matching index is what remains
    always_comb begin
        logic match;
        hit   = 1'b0;
        idx   = 4'h0;
        match = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            match = ((region & REGION_MASK[4*i +: 4]) == REGION_BASE[4*i +: 4]);
            hit   = hit | match;
            idx   = match ? 4'(i) : idx;
        end
    end

endmodule

// File: rtl/mmio_fabric.sv
// MMIO interconnect: decodes CPU accesses onto N slaves, waits for the
// selected slave's ready, and turns unmapped or timed-out accesses into bus
// errors with a recorded fault address, saturating count and irq pulse.
module mmio_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int                         N_SLAVES    = 9,
    parameter logic [N_SLAVES*4-1:0]      REGION_BASE = {N_SLAVES{4'h0}},
    parameter logic [N_SLAVES*4-1:0]      REGION_MASK = {N_SLAVES{4'hE}},
    parameter int                         TIMEOUT     = 16,
    parameter int                         CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_fabric_if.slave      bus,
    output logic [31:0]       fault_addr,
    output logic [CNT_W-1:0]  fault_count,
    output logic              fault_irq
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    fab_state_t          state_r, state_nxt_s;
    logic                err_nxt_s;
    logic                hit_s;
    logic [IDX_W-1:0]    hit_idx_s;
    logic [15:0]         onehot_wide_s;
    logic [N_SLAVES-1:0] onehot_s;
    logic                slv_done_s;
    logic                tmo_s;
    logic [31:0]         sel_rdata_s;
    logic                accept_s;

    logic                req_ready_r;
    logic                resp_valid_r;
    logic [31:0]         resp_rdata_r;
    logic                resp_err_r;
    logic [N_SLAVES-1:0] slv_sel_r;
    logic [31:0]         slv_addr_r;
    logic [31:0]         slv_wdata_r;
    logic [3:0]          slv_wstrb_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [31:0]         fault_addr_r;
    logic [CNT_W-1:0]    fault_count_r;
    logic                fault_irq_r;

    mmio_region_match #(
        .N_SLAVES    (N_SLAVES),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_region_match (
        .region (bus.req_addr[31:28]),
        .hit    (hit_s),
        .idx    (hit_idx_s)
    );

    assign onehot_wide_s = idx_to_onehot(hit_idx_s);
    assign onehot_s      = onehot_wide_s[N_SLAVES-1:0];
    assign accept_s      = (state_r == ST_IDLE) && bus.req_valid;
    assign slv_done_s    = |(bus.slv_ready & slv_sel_r);
    assign tmo_s         = (TIMEOUT != 0) && (tmo_cnt_r == TMO_LAST);

    // Read data of the currently selected slave (select is one-hot)
    always_comb begin
        sel_rdata_s = 32'h0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_rdata_s = sel_rdata_s | (bus.slv_rdata[32*i +: 32] & {32{slv_sel_r[i]}});
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and error decision for the upcoming response
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (hit_s) begin
                        state_nxt_s = ST_ACCESS;
                    end else begin
                        state_nxt_s = ST_RESP;
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (slv_done_s) begin
                    state_nxt_s = ST_RESP;
                end else if (tmo_s) begin
                    state_nxt_s = ST_RESP;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request latch, slave drive, response and fault registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 32'h0;
            resp_err_r    <= 1'b0;
            slv_sel_r     <= '0;
            slv_addr_r    <= 32'h0;
            slv_wdata_r   <= 32'h0;
            slv_wstrb_r   <= 4'h0;
            tmo_cnt_r     <= '0;
            fault_addr_r  <= 32'h0;
            fault_count_r <= '0;
            fault_irq_r   <= 1'b0;
        end else begin
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            fault_irq_r  <= (state_nxt_s == ST_RESP) && err_nxt_s;

            if (accept_s) begin
                slv_addr_r  <= bus.req_addr;
                slv_wdata_r <= bus.req_wdata;
            end

            // Select and strobes only live in ACCESS; errored writes never get here
            if (state_nxt_s == ST_ACCESS) begin
                slv_sel_r   <= accept_s ? onehot_s : slv_sel_r;
                slv_wstrb_r <= accept_s ? bus.req_wstrb : slv_wstrb_r;
            end else begin
                slv_sel_r   <= '0;
                slv_wstrb_r <= 4'h0;
            end

            if ((state_r == ST_ACCESS) && (state_nxt_s == ST_ACCESS)) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= '0;
            end

            if (state_nxt_s == ST_RESP) begin
                resp_err_r   <= err_nxt_s;
                resp_rdata_r <= err_nxt_s ? 32'h0 : sel_rdata_s;
            end

            // Unmapped errors come straight from IDLE, before slv_addr_r is loaded
            if ((state_nxt_s == ST_RESP) && err_nxt_s) begin
                fault_addr_r <= accept_s ? bus.req_addr : slv_addr_r;
                if (fault_count_r != {CNT_W{1'b1}}) begin
                    fault_count_r <= fault_count_r + CNT_W'(1);
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.slv_sel    = slv_sel_r;
    assign bus.slv_addr   = slv_addr_r;
    assign bus.slv_wdata  = slv_wdata_r;
    assign bus.slv_wstrb  = slv_wstrb_r;
    assign fault_addr     = fault_addr_r;
    assign fault_count    = fault_count_r;
    assign fault_irq      = fault_irq_r;

endmodule

// File: tb/tb_mmio_fabric.sv
// Bench for mmio_fabric: directed requests push expected responses into a
// scoreboard queue; a monitor checks slave-side drive every cycle and pops
// and compares each response (data, error, latency, fault registers).
module tb_mmio_fabric;
    import mmio_fabric_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        logic [8:0]  sel;
        int          cyc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    item_t       q[$];

    logic [31:0] fault_addr;
    logic [7:0]  fault_count;
    logic        fault_irq;

    int          wait_cfg [9] = '{0, 0, 1, 0, 0, -1, 0, 3, 2};
    logic [8:0]  ready_v = 9'h0;
    logic [8:0]  noise = 9'h0;
    int          sel_cyc = 0;
    logic [9*32-1:0] rdata_flat;

    mmio_fabric_if #(.N_SLAVES(9)) bus ();

    mmio_fabric #(
        .N_SLAVES    (9),
        .REGION_BASE (SOC_REGION_BASE),
        .REGION_MASK (SOC_REGION_MASK),
        .TIMEOUT     (16),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .fault_addr  (fault_addr),
        .fault_count (fault_count),
        .fault_irq   (fault_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave read data: slave0 returns DEADBEEF, others A000_000i
    always_comb begin
        rdata_flat = '0;
        for (int i = 0; i < 9; i++) begin
            rdata_flat[32*i +: 32] = (i == 0) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
        end
    end
    assign bus.slv_rdata = rdata_flat;
    assign bus.slv_ready = ready_v | noise;

    // Slave model: ready after wait_cfg[i] selected cycles, never if negative
    always @(negedge clk) begin
        if (bus.slv_sel == 9'h0) begin
            sel_cyc <= 0;
            ready_v <= 9'h0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                ready_v[i] <= bus.slv_sel[i] && (wait_cfg[i] >= 0) && (sel_cyc == wait_cfg[i]);
            end
            sel_cyc <= sel_cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: slave-side drive every cycle, responses against the scoreboard
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.slv_sel != 9'h0 || bus.slv_wstrb != 4'h0) begin
                    if (q.size() == 0) begin
                        chk("slv_sel_unexpected", 32'(bus.slv_sel), 32'h0);
                    end else begin
                        chk("slv_sel", 32'(bus.slv_sel), 32'(q[0].sel));
                        chk("slv_wstrb", 32'(bus.slv_wstrb), (q[0].sel != 9'h0) ? 32'(q[0].strb) : 32'h0);
                        chk("slv_addr", bus.slv_addr, q[0].addr);
                        chk("slv_wdata", bus.slv_wdata, q[0].wdata);
                    end
                end
                if (fault_irq && !bus.resp_valid) chk("irq_without_resp", 32'(fault_irq), 32'h0);
                if (bus.resp_valid) begin
                    if (q.size() == 0) begin
                        chk("resp_unexpected", 32'(bus.resp_valid), 32'h0);
                    end else begin
                        it = q.pop_front();
                        chk("resp_rdata", bus.resp_rdata, it.rdata);
                        chk("resp_err", 32'(bus.resp_err), 32'(it.err));
                        chk("resp_latency", 32'(cyc), 32'(it.cyc));
                        chk("fault_irq", 32'(fault_irq), 32'(it.err));
                        if (it.err) begin
                            if (exp_cnt < 255) exp_cnt++;
                            chk("fault_addr", fault_addr, it.addr);
                        end
                        chk("fault_count", 32'(fault_count), 32'(exp_cnt));
                    end
                end
            end
        end
    end

    // Wait for an idle fabric, push the expectation, present the request for one accept cycle
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input logic [31:0] rd, input logic e, input logic [8:0] s, input int lat);
        item_t it;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_ready_wait", 32'(bus.req_ready), 32'h1);
        it.addr = a; it.wdata = wd; it.strb = st; it.rdata = rd;
        it.err = e; it.sel = s; it.cyc = cyc + lat;
        q.push_back(it);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_wstrb = st;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            chk("resp_missing", 32'(q.size()), 32'h0);
            q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},  32'(bus.req_ready),  32'h1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata,      32'h0);
        chk({tag, "_resp_err"},   32'(bus.resp_err),   32'h0);
        chk({tag, "_slv_sel"},    32'(bus.slv_sel),    32'h0);
        chk({tag, "_slv_addr"},   bus.slv_addr,        32'h0);
        chk({tag, "_slv_wdata"},  bus.slv_wdata,       32'h0);
        chk({tag, "_slv_wstrb"},  32'(bus.slv_wstrb),  32'h0);
        chk({tag, "_fault_addr"}, fault_addr,          32'h0);
        chk({tag, "_fault_count"}, 32'(fault_count),   32'h0);
        chk({tag, "_fault_irq"},  32'(fault_irq),      32'h0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait read of RAM, with a non-selected slave holding ready high
        noise = 9'h002;
        issue(32'h0000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 9'h001, 2);
        drain();
        // LCD write with three wait cycles
        issue(32'hC000_0001, 32'h1234_5678, 4'b0011, 32'hA000_0007, 1'b0, 9'h080, 5);
        drain();
        noise = 9'h0;

        // Overlapping regions: 0x4 and 0x5 both go to slave 2
        issue(32'h4000_0100, 32'h0, 4'h0, 32'hA000_0002, 1'b0, 9'h004, 3);
        drain();
        issue(32'h5000_0000, 32'h0, 4'h0, 32'hA000_0002, 1'b0, 9'h004, 3);
        drain();
        issue(32'h2000_0000, 32'h0, 4'h0, 32'hA000_0001, 1'b0, 9'h002, 2);
        drain();
        issue(32'hE000_0008, 32'h55AA_55AA, 4'b1000, 32'hA000_0008, 1'b0, 9'h100, 4);
        drain();

        // Timeout on a never-ready slave; a stray request mid-access is ignored
        issue(32'h8000_0040, 32'h0, 4'h0, 32'h0, 1'b1, 9'h020, 17);
        repeat (4) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0020;
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain();
        chk("fault_count_first", 32'(fault_count), 32'h1);

        // Unmapped writes: immediate error, no select, counter saturates
        for (int i = 0; i < 300; i++) begin
            issue(32'hF000_0000 + 32'(i * 4), 32'hCAFE_0000 + 32'(i), 4'b1111, 32'h0, 1'b1, 9'h000, 1);
            drain();
        end
        chk("fault_count_sat", 32'(fault_count), 32'd255);

        // Reset in the middle of an access drops it without a response
        issue(32'h8000_0004, 32'h0, 4'h0, 32'h0, 1'b1, 9'h020, 17);
        repeat (4) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        q.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(32'h0000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 9'h001, 2);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
